// File: rtl/serial_bit_sender_pkg.sv
// Shared definitions for the serial_bit_sender block.
//   state_t : FSM state encodings (IDLE / SEND / DONE)
//   clog2   : ceiling log2 helper used to size counters; returns at least 1
package serial_bit_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_bit_sender_bit_hold_timer.sv
// bit_hold_timer: counts the cycles a serial bit has been on the line and
// flags the final hold cycle of each bit.
//   HOLD_CYCLES : cycles each bit stays on the line (>= 1)
//   i_clk       : system clock, rising edge
//   i_rst       : synchronous reset, active-high
//   i_run       : counting enable; the count is held at zero while low
//   o_last      : high during the last hold cycle of the current bit
module bit_hold_timer
  import serial_bit_sender_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_last
);

  localparam int HW = clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_q;

  assign o_last = i_run && (hold_q == LAST_HOLD);

  // Wrapping to zero on o_last keeps the count inside 0..HOLD_CYCLES-1.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      hold_q <= '0;
    end else if (o_last) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_q + HW'(1);
    end
  end

endmodule

// File: rtl/serial_bit_sender.sv
// serial_bit_sender: serializes a parallel word MSB first onto o_data with a
// write-enable strobe o_en for a downstream enable-DFF / shift-capture chain.
// Each bit is held HOLD_CYCLES cycles; o_en marks the last hold cycle so the
// receiver captures stable data at the following edge.
//
// Handshake: i_start is sampled only in IDLE; the edge that sees i_start=1
// captures i_word. i_start in SEND or DONE is ignored (not queued). o_done
// pulses for one cycle after the final strobe; o_busy covers SEND and DONE.
//
// Optional macro SERIAL_SENDER_PARITY_EN: append one even-parity bit (XOR of
// the captured word) after the data bits, using the same hold/strobe timing.
//
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst   : synchronous reset, active-high (priority over i_start)
//   i_start : start request
//   i_word  : word to send
//   o_data  : serial bit, MSB first (0 outside SEND)
//   o_en    : receiver write-enable strobe
//   o_busy  : word in flight
//   o_done  : one-cycle completion pulse
module serial_bit_sender
  import serial_bit_sender_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_data,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_done
);

`ifdef SERIAL_SENDER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BW = clog2(NBITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("serial_bit_sender: HOLD_CYCLES must be >= 1");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_bit_sender: WIDTH must be >= 2");
  end

  state_t            state_q, state_d;
  logic [NBITS-1:0]  shift_q;
  logic [NBITS-1:0]  load_word;
  logic [BW-1:0]     bit_cnt_q;
  logic              load;
  logic              send_active;
  logic              bit_last;

  // The parity bit rides in the LSB of the shift register so it falls out
  // naturally after the data bits.
`ifdef SERIAL_SENDER_PARITY_EN
  assign load_word = {i_word, ^i_word};
`else
  assign load_word = i_word;
`endif

  assign send_active = (state_q == ST_SEND);

  bit_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_run (send_active),
    .o_last(bit_last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    o_data  = 1'b0;
    o_en    = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SEND;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        o_data = shift_q[NBITS-1];
        o_en   = bit_last;
        o_busy = 1'b1;
        if (bit_last && (bit_cnt_q == LAST_BIT)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        o_busy  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        shift_q   <= load_word;
        bit_cnt_q <= '0;
      end else if (send_active && bit_last) begin
        shift_q   <= {shift_q[NBITS-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + BW'(1);
      end
    end
  end

endmodule
